// File: rtl/hamming_decoder_38_32.sv
`default_nettype none
// ============================================================================
// Module   : hamming_decoder_38_32
// Brief    : Two-stage SEC Hamming(38,32) decoder with valid/ready handshake
//            and saturating correction statistics.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_decoder_38_32 #(
    parameter int CW_W   = 38,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    input  logic              stat_clear,
    output logic [CNT_W-1:0]  corrected_count,
    output logic [CNT_W-1:0]  uncorrectable_count
);

    localparam logic [5:0]       c_max_pos = 6'(CW_W);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Bitmask of codeword positions whose index has bit j set.
    function automatic logic [CW_W-1:0] f_mask(input int j);
        logic [CW_W-1:0] m;
        m = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (((p >> j) & 1) == 1) m[p-1] = 1'b1;
        end
        return m;
    endfunction

    // Hamming position (1-based) of data bit k: k-th non-power-of-two position.
    function automatic int f_pos(input int k);
        int n;
        int res;
        n   = 0;
        res = 0;
        for (int p = 1; p <= CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == k) res = p;
                n++;
            end
        end
        return res;
    endfunction

    logic [5:0]        w_syn;
    logic [DATA_W-1:0] w_in_data;
    logic [DATA_W-1:0] w_dflip;
    logic              w_s2_adv;
    logic              w_xfer;
    logic              w_is_corr;
    logic              w_is_unc;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [5:0]        r_s1_syn;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [5:0]        r_out_syn;
    logic              r_out_corr;
    logic              r_out_unc;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_unc_cnt;

    for (genvar j = 0; j < 6; j++) begin : g_syn
        localparam logic [CW_W-1:0] c_mask = f_mask(j);
        assign w_syn[j] = ^(in_codeword & c_mask);
    end

    // S1 keeps only the payload bits; a single-bit error on a data position
    // is repaired in S2 by matching the syndrome against that bit's position.
    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        localparam int c_pos = f_pos(k);
        assign w_in_data[k] = in_codeword[c_pos-1];
        assign w_dflip[k]   = (r_s1_syn == 6'(c_pos));
    end

    assign w_is_corr = (r_s1_syn != 6'd0) && (r_s1_syn <= c_max_pos);
    assign w_is_unc  = (r_s1_syn > c_max_pos);
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_xfer    = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            r_s1_data <= w_in_data;
            r_s1_syn  <= w_syn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_syn  <= '0;
            r_out_corr <= 1'b0;
            r_out_unc  <= 1'b0;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= r_s1_data ^ w_dflip;
                    r_out_syn  <= r_s1_syn;
                    r_out_corr <= w_is_corr;
                    r_out_unc  <= w_is_unc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
        end else if (stat_clear) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
        end else if (w_xfer) begin
            if (r_out_corr && (r_corr_cnt != c_cnt_max)) r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            if (r_out_unc && (r_unc_cnt != c_cnt_max))   r_unc_cnt  <= r_unc_cnt + CNT_W'(1);
        end
    end

    assign out_valid           = r_s2_valid;
    assign out_data            = r_out_data;
    assign out_syndrome        = r_out_syn;
    assign out_corrected       = r_out_corr;
    assign out_uncorrectable   = r_out_unc;
    assign corrected_count     = r_corr_cnt;
    assign uncorrectable_count = r_unc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder_38_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_decoder_38_32
// Brief    : Randomised bench for hamming_decoder_38_32 against a positional
//            Hamming model with an output queue and counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_decoder_38_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] in_codeword;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorrectable;
    logic        stat_clear;
    logic [15:0] corrected_count;
    logic [15:0] uncorrectable_count;

    hamming_decoder_38_32 dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_codeword         (in_codeword),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_syndrome        (out_syndrome),
        .out_corrected       (out_corrected),
        .out_uncorrectable   (out_uncorrectable),
        .stat_clear          (stat_clear),
        .corrected_count     (corrected_count),
        .uncorrectable_count (uncorrectable_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  s;
        logic        c;
        logic        u;
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Syndrome is simply the XOR of the positions of all set bits.
    function automatic logic [5:0] m_syn(input logic [37:0] cw);
        int s = 0;
        for (int p = 1; p <= 38; p++) if (cw[p-1]) s ^= p;
        return 6'(s);
    endfunction

    function automatic logic [31:0] m_extract(input logic [37:0] cw);
        logic [31:0] d = '0;
        int k = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p-1];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [37:0] m_encode(input logic [31:0] d);
        logic [37:0] cw = '0;
        logic [5:0]  s;
        int k = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        s = m_syn(cw);
        for (int j = 0; j < 6; j++) cw[(1 << j) - 1] = s[j];
        return cw;
    endfunction

    function automatic exp_t m_decode(input logic [37:0] cw);
        exp_t        e;
        logic [37:0] c = cw;
        int          s = int'(m_syn(cw));
        if (s >= 1 && s <= 38) c[s-1] = ~c[s-1];
        e.d = m_extract(c);
        e.s = 6'(s);
        e.c = (s >= 1 && s <= 38);
        e.u = (s > 38);
        return e;
    endfunction

    function automatic logic [37:0] gen_word();
        logic [37:0] cw = m_encode($urandom);
        int a = $urandom_range(0, 37);
        int b = (a + $urandom_range(1, 37)) % 38;
        case ($urandom_range(0, 3))
            0: ;
            1: cw[a] = ~cw[a];
            2: begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; end
            default: cw = {6'($urandom), 32'($urandom)};
        endcase
        return cw;
    endfunction

    // ---------------- compare process: queue + counter model ----------------
    exp_t        q[$];
    exp_t        e_pop;
    int          mc_corr = 0;
    int          mc_unc  = 0;
    logic        prev_stall = 1'b0;
    logic [39:0] prev_vec;
    logic        x_corr;
    logic        x_unc;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mc_corr    = 0;
            mc_unc     = 0;
            prev_stall = 1'b0;
            chk("reset_out_valid", 64'(out_valid), 64'd0);
        end else begin
            chk("corrected_count", 64'(corrected_count), 64'(mc_corr));
            chk("uncorrectable_count", 64'(uncorrectable_count), 64'(mc_unc));
            if (prev_stall)
                chk("stall_hold", 64'({out_data, out_syndrome, out_corrected, out_uncorrectable}), 64'(prev_vec));
            x_corr = 1'b0;
            x_unc  = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stale_word", 64'(out_valid), 64'd0);
                end else begin
                    e_pop = q.pop_front();
                    chk("word", 64'({out_data, out_syndrome, out_corrected, out_uncorrectable}), 64'(e_pop));
                    x_corr = e_pop.c;
                    x_unc  = e_pop.u;
                end
            end
            if (in_valid && in_ready) q.push_back(m_decode(in_codeword));
            if (stat_clear) begin
                mc_corr = 0;
                mc_unc  = 0;
            end else begin
                if (x_corr && mc_corr < 65535) mc_corr++;
                if (x_unc && mc_unc < 65535)   mc_unc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = {out_data, out_syndrome, out_corrected, out_uncorrectable};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_word(input logic [37:0] cw);
        logic acc;
        int   t = 0;
        in_valid    = 1'b1;
        in_codeword = cw;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 100) begin
                chk("accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic send_check(input string name, input logic [37:0] cw, input exp_t e);
        int n = 0;
        drive_word(cw);
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        chk({name, "_latency"}, 64'(n), 64'd2);
        chk(name, 64'({out_data, out_syndrome, out_corrected, out_uncorrectable}), 64'(e));
        @(posedge clk);
        #1;
    endtask

    logic [37:0] w[4];
    int          acc_n;
    int          guard;
    logic [37:0] lit_cw;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_codeword = '0;
        out_ready   = 1'b1;
        stat_clear  = 1'b0;

        lit_cw = 38'h2000000001;
        chk("model_syn_pos3", 64'(m_syn(38'h0000000004)), 64'd3);
        chk("model_unc", 64'(m_decode(lit_cw)), 64'({32'h80000000, 6'd39, 1'b0, 1'b1}));
        chk("model_enc_syn", 64'(m_syn(m_encode(32'hDEADBEEF))), 64'd0);
        chk("model_enc_ext", 64'(m_extract(m_encode(32'hDEADBEEF))), 64'hDEADBEEF);

        #1;
        chk("reset_outputs", 64'({out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable}), 64'd0);
        chk("reset_counts", 64'({corrected_count, uncorrectable_count}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_check("zero_word", 38'h0, {32'h0, 6'd0, 1'b0, 1'b0});
        send_check("pos3_flip", 38'h0000000004, {32'h0, 6'd3, 1'b1, 1'b0});
        chk("corr_count_1", 64'(corrected_count), 64'd1);
        send_check("parity_flip", 38'h0000000001, {32'h0, 6'd1, 1'b1, 1'b0});
        send_check("uncorrectable", lit_cw, {32'h80000000, 6'd39, 1'b0, 1'b1});
        chk("unc_count_1", 64'(uncorrectable_count), 64'd1);

        // Stall: 4 words against a blocked output.
        for (int i = 0; i < 4; i++) w[i] = gen_word();
        out_ready = 1'b0;
        acc_n     = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid    = 1'b1;
            in_codeword = w[acc_n];
            @(negedge clk);
            if (in_ready) acc_n++;
            @(posedge clk);
            #1;
        end
        chk("stall_accepts", 64'(acc_n), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        fork
            begin
                drive_word(w[2]);
                drive_word(w[3]);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("no_gap", 64'(out_valid), 64'd1);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Saturation of the corrected counter.
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear  = 1'b0;
        acc_n       = 0;
        guard       = 0;
        in_valid    = 1'b1;
        in_codeword = 38'h0000000004;
        while (acc_n < 65535 && guard < 70000) begin
            @(negedge clk);
            if (in_ready) acc_n++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("sat_stream_done", 64'(acc_n), 64'd65535);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_at_max", 64'(corrected_count), 64'hFFFF);
        send_check("sat_extra", 38'h0000000004, {32'h0, 6'd3, 1'b1, 1'b0});
        chk("sat_hold", 64'(corrected_count), 64'hFFFF);

        // Clear coincident with a corrected transfer.
        stat_clear = 1'b1;
        drive_word(38'h0000000004);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        stat_clear = 1'b0;
        @(posedge clk);
        #1;
        chk("clear_priority", 64'(corrected_count), 64'd0);

        // Randomised traffic with backpressure.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            stat_clear  = ($urandom_range(0, 199) == 0);
            in_codeword = gen_word();
            @(posedge clk);
            #1;
        end
        stat_clear = 1'b0;

        // Asynchronous reset mid-stream.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid    = 1'b1;
            in_codeword = gen_word();
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_outputs", 64'({out_data, out_syndrome, out_corrected, out_uncorrectable}), 64'd0);
        chk("midrst_counts", 64'({corrected_count, uncorrectable_count}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale_after_reset", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        for (int c = 0; c < 500; c++) begin
            in_valid    = ($urandom_range(0, 1) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            in_codeword = gen_word();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_decoder_38_32.md
Name: hamming_decoder_38_32

Overview:
- Pipelined SEC Hamming(38,32) decoder/corrector. Sits directly downstream of the error-injection stage.
- Consumes 38-bit encoded words, possibly corrupted. Computes the 6-bit syndrome, corrects any single-bit error and extracts the 32-bit payload.
- Flags words it cannot correct and keeps running statistics.
- Valid/ready handshake on both sides; 2-stage pipeline with full backpressure.

Parameters:
- CW_W, 38, codeword width (fixed by the code; must not be overridden)
- DATA_W, 32, payload width
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  decoder can accept a word this cycle
- in_codeword  input  38  encoded word; bit i = Hamming position i+1
- out_valid  output  1  decoded word valid
- out_ready  input  1  downstream accepts the word
- out_data  output  32  corrected payload
- out_syndrome  output  6  syndrome of this word
- out_corrected  output  1  single error found and fixed
- out_uncorrectable  output  1  syndrome > 38; payload passed uncorrected
- stat_clear  input  1  synchronous clear of both counters
- corrected_count  output  16  saturating count of corrected words
- uncorrectable_count  output  16  saturating count of uncorrectable words

Behaviour:
- Code layout
  - Parity bits sit at positions 1, 2, 4, 8, 16, 32.
  - Data bits fill the remaining positions in ascending order: pos3→d0, pos5–7→d1–d3, pos9–15→d4–d10, pos17–31→d11–d25, pos33–38→d26–d31.
- Syndrome: s[j] = XOR of all codeword positions p (1..38) with bit j of p set.
- Stage 1 (S1): on accept, registers in_codeword and the computed syndrome.
- Stage 2 (S2): registers the outputs.
  - syn==0: no flip; corrected=0, uncorrectable=0.
  - 1≤syn≤38: flip bit syn-1, then extract data; corrected=1. A parity-bit flip still sets corrected=1 but leaves the data unchanged.
  - syn≥39: no flip; uncorrectable=1; data is the raw extraction.
- Handshake
  - s2_adv = !s2_valid | out_ready
  - in_ready = !s1_valid | s2_adv (combinational, no dependence on in_valid)
  - A word is accepted when in_valid & in_ready. S1 moves to S2 when s1_valid & s2_adv.
- Latency
  - 2 cycles from accept to out_valid when unstalled; throughput 1 word/cycle.
  - out_* is held stable while out_valid & !out_ready.
- Backpressure: with out_ready low, S2 holds and S1 fills. in_ready then drops; no word is lost or duplicated.
- Counters
  - Each counter increments once per word transferred out (out_valid & out_ready) with the matching flag.
  - Saturate at 16'hFFFF.
  - stat_clear zeroes both counters and has priority over a same-cycle increment.
- Reset (asynchronous, any time including mid-operation)
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - out_data, out_syndrome, out_corrected, out_uncorrectable = 0.
  - Both counters = 0.
  - in_ready reads 1 after reset. In-flight words are discarded.
- The pipeline data registers need no reset beyond the listed outputs; valid bits gate everything else.

Test Plan:
- Reset, then in_codeword=38'h0 with out_ready=1 → 2 cycles later out_data=32'h0, syndrome=0, corrected=0, uncorrectable=0.
- in_codeword=38'h0000000004 (pos3 flipped) → syndrome=6'd3, out_data=32'h0, corrected=1, corrected_count=1.
- in_codeword=38'h0000000001 (parity pos1 flipped) → syndrome=1, out_data=0, corrected=1.
- in_codeword with bits 0 and 37 set → syndrome=6'd39, uncorrectable=1, out_data=32'h80000000, uncorrectable_count=1.
- Stream 4 words while out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - out_* stays stable while stalled.
  - Raising out_ready delivers all 4 words in order, no gaps.
- Preload corrected_count to FFFF via 65535 corrected words, send one more → count stays FFFF. Assert stat_clear together with a corrected transfer → count=0. Assert rst_n low mid-stream → out_valid=0 immediately and no stale word appears after release.
